// File: rtl/exec_muldiv_pkg.sv
// rtl/exec_muldiv_pkg.sv - op codes and FSM states for the execute-stage mul/div unit
package exec_muldiv_pkg;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_MULT  = 5'd1;
  localparam logic [4:0] ALU_MULTU = 5'd2;
  localparam logic [4:0] ALU_DIV   = 5'd3;
  localparam logic [4:0] ALU_DIVU  = 5'd4;
  localparam logic [4:0] ALU_MFHI  = 5'd5;
  localparam logic [4:0] ALU_MFLO  = 5'd6;
  localparam logic [4:0] ALU_MTHI  = 5'd7;
  localparam logic [4:0] ALU_MTLO  = 5'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_iter32.sv
// rtl/div_iter32.sv - unsigned restoring divider, one quotient bit per clock
module div_iter32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic          active;
  logic [CW-1:0] count;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  quo_next;

  // A zero divisor never borrows, so it naturally yields all-ones and rem=dividend.
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    trial    = shifted - {1'b0, dvs_q};
    rem_next = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    quo_next = {quo_q[W-2:0], ~trial[W]};
  end

  assign done      = active && (count == CW'(W-1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
    end else if (active) begin
      rem_q  <= rem_next;
      quo_q  <= quo_next;
      count  <= count + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// rtl/exec_muldiv.sv - execute-stage MULT/DIV unit with HI/LO and pipeline stall request
module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_in,
  input  logic [DATA_WIDTH-1:0]   rs_in,
  input  logic [DATA_WIDTH-1:0]   rt_in,
  output logic                    stall_req,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [DATA_WIDTH-1:0]   hi_out,
  output logic [DATA_WIDTH-1:0]   lo_out,
  output logic                    busy
);

  localparam int W = DATA_WIDTH;

  state_t          state, state_next;
  logic [W-1:0]    hi, lo;
  logic [W-1:0]    mul_a, mul_b;
  logic            mul_signed;
  logic            q_neg, r_neg, div_by_zero;
  logic            is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic            start_mul, start_div;
  logic [W-1:0]    div_a, div_b;
  logic [2*W-1:0]  ext_a, ext_b, product;
  logic            div_rst, div_done;
  logic [W-1:0]    div_quo, div_rem;

  always_comb begin
    is_mult  = (alu_op_in == ALU_OP_WIDTH'(ALU_MULT));
    is_multu = (alu_op_in == ALU_OP_WIDTH'(ALU_MULTU));
    is_div   = (alu_op_in == ALU_OP_WIDTH'(ALU_DIV));
    is_divu  = (alu_op_in == ALU_OP_WIDTH'(ALU_DIVU));
    is_mfhi  = (alu_op_in == ALU_OP_WIDTH'(ALU_MFHI));
    is_mflo  = (alu_op_in == ALU_OP_WIDTH'(ALU_MFLO));
    is_mthi  = (alu_op_in == ALU_OP_WIDTH'(ALU_MTHI));
    is_mtlo  = (alu_op_in == ALU_OP_WIDTH'(ALU_MTLO));
    start_mul = (state == ST_IDLE) && !flush && (is_mult || is_multu);
    start_div = (state == ST_IDLE) && !flush && (is_div || is_divu);
    div_a = (is_div && rs_in[W-1]) ? -rs_in : rs_in;
    div_b = (is_div && rt_in[W-1]) ? -rt_in : rt_in;
  end

  // Extending to 2W bits lets one multiplier serve both signed and unsigned products.
  assign ext_a   = {{W{mul_signed & mul_a[W-1]}}, mul_a};
  assign ext_b   = {{W{mul_signed & mul_b[W-1]}}, mul_b};
  assign product = ext_a * ext_b;

  assign div_rst = rst || flush;

  div_iter32 #(.W(W)) u_div (
    .clk       (clk),
    .rst       (div_rst),
    .start     (start_div),
    .dividend  (div_a),
    .divisor   (div_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)      state_next = ST_MUL;
        else if (start_div) state_next = ST_DIV;
      end
      ST_MUL:  state_next = ST_DONE;
      ST_DIV:  if (div_done) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hi          <= '0;
      lo          <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_signed  <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (start_mul) begin
        mul_a      <= rs_in;
        mul_b      <= rt_in;
        mul_signed <= is_mult;
      end
      if (start_div) begin
        q_neg       <= is_div && (rs_in[W-1] ^ rt_in[W-1]);
        r_neg       <= is_div && rs_in[W-1];
        div_by_zero <= (rt_in == '0);
      end
      if (!flush) begin
        if (state == ST_MUL) begin
          {hi, lo} <= product;
        end else if (state == ST_DIV && div_done) begin
          hi <= r_neg ? -div_rem : div_rem;
          lo <= div_by_zero ? '1 : (q_neg ? -div_quo : div_quo);
        end else if (state == ST_IDLE) begin
          if (is_mthi) hi <= rs_in;
          if (is_mtlo) lo <= rs_in;
        end
      end
    end
  end

  always_comb begin
    result = '0;
    if (is_mfhi)      result = hi;
    else if (is_mflo) result = lo;
  end

  assign stall_req = start_mul || start_div || (state == ST_MUL) || (state == ST_DIV);
  assign busy      = (state != ST_IDLE);
  assign hi_out    = hi;
  assign lo_out    = lo;

endmodule
